// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] CODE_L_UP_DEF = 8'h1D;
  localparam logic [7:0] CODE_L_DN_DEF = 8'h1B;
  localparam logic [7:0] CODE_R_UP_DEF = 8'h75;
  localparam logic [7:0] CODE_R_DN_DEF = 8'h72;

  localparam int TIMEOUT_CYC_DEF = 100000;

  // Counter must hold TIMEOUT_CYC-1; keep at least one bit for tiny values.
  function automatic int tmo_width(input int timeout_cyc);
    return (timeout_cyc <= 2) ? 1 : $clog2(timeout_cyc);
  endfunction

  localparam int TMO_W_DEF = tmo_width(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 pins, deglitches the clock and emits a falling-edge
// strobe together with the data level sampled on that edge.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic fall_o,
  output logic dat_o
);

  logic [1:0]            clk_sync_q;
  logic [1:0]            dat_sync_q;
  logic [FILTER_LEN-1:0] samp_q, samp_d;
  logic                  filt_q, filt_d;
  logic                  fall_q, fall_d;
  logic                  dat_q, dat_d;
  logic                  all_lo, all_hi;

  assign all_lo = (samp_q == '0);
  assign all_hi = (&samp_q);

  always_comb begin
    samp_d = {samp_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_d = filt_q;
    if (all_lo)      filt_d = 1'b0;
    else if (all_hi) filt_d = 1'b1;
    fall_d = filt_q & all_lo;
    dat_d  = fall_d ? dat_sync_q[1] : dat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      samp_q     <= '1;
      filt_q     <= 1'b1;
      fall_q     <= 1'b0;
      dat_q      <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      samp_q     <= samp_d;
      filt_q     <= filt_d;
      fall_q     <= fall_d;
      dat_q      <= dat_d;
    end
  end

  assign fall_o = fall_q;
  assign dat_o  = dat_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame FSM with timeout plus make/break decoder
// driving active-low paddle key states.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int         FILTER_LEN  = 8,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [7:0] CODE_L_UP   = CODE_L_UP_DEF,
  parameter logic [7:0] CODE_L_DN   = CODE_L_DN_DEF,
  parameter logic [7:0] CODE_R_UP   = CODE_R_UP_DEF,
  parameter logic [7:0] CODE_R_DN   = CODE_R_DN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic [1:0] keys_left,
  output logic [1:0] keys_right
);

  localparam int TW = tmo_width(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic fall, dat;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk_i(ps2_clk),
    .ps2_dat_i(ps2_dat),
    .fall_o   (fall),
    .dat_o    (dat)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          scan_valid_q, scan_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    keys_left_q, keys_left_d;
  logic [1:0]    keys_right_q, keys_right_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic          tmo_hit;

  assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);

    // Timeout wins over a coincident fall so only one error pulse results.
    if (tmo_hit) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      tmo_d       = '0;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat;
          state_d = STOP;
        end
        STOP: begin
          if (dat && ((^shift_q) ^ par_q)) begin
            scan_code_d  = shift_q;
            scan_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    keys_left_d  = keys_left_q;
    keys_right_d = keys_right_q;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    if (frame_err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (scan_valid_q) begin
      if (scan_code_q == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else if (scan_code_q == PS2_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        if (!ext_pend_q && scan_code_q == CODE_L_UP) keys_left_d[1]  = brk_pend_q;
        if (!ext_pend_q && scan_code_q == CODE_L_DN) keys_left_d[0]  = brk_pend_q;
        if ( ext_pend_q && scan_code_q == CODE_R_UP) keys_right_d[1] = brk_pend_q;
        if ( ext_pend_q && scan_code_q == CODE_R_DN) keys_right_d[0] = brk_pend_q;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      scan_code_q  <= 8'd0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      keys_left_q  <= 2'b11;
      keys_right_q <= 2'b11;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      keys_left_q  <= keys_left_d;
      keys_right_q <= keys_right_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
    end
  end

  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;
  assign keys_left  = keys_left_q;
  assign keys_right = keys_right_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed and randomized PS/2 frames checked against a key-state model.
module tb_ps2_keyboard_rx;

  localparam int FLT  = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;
  logic [1:0] keys_left, keys_right;

  ps2_keyboard_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err),
    .keys_left (keys_left),
    .keys_right(keys_right)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0, sv_cnt = 0, fe_cnt = 0, fall_cnt = 0;
  int last_fall_cyc = 0, sv_lat = 0, sv_double = 0;
  logic prev_sv = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (scan_valid) begin
      sv_cnt <= sv_cnt + 1;
      sv_lat <= cyc - last_fall_cyc;
      if (prev_sv) sv_double <= sv_double + 1;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (dut.u_filt.fall_o) begin
      fall_cnt      <= fall_cnt + 1;
      last_fall_cyc <= cyc;
    end
    prev_sv <= scan_valid;
  end

  // Reference: key states as the game would see them after each decoded byte.
  logic [1:0] m_kl = 2'b11, m_kr = 2'b11;
  logic [7:0] m_code = 8'h00;
  bit m_ext = 0, m_brk = 0;

  task automatic model_byte(input logic [7:0] b);
    m_code = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_ext) begin
        if (b == 8'h1D) m_kl[1] = m_brk;
        if (b == 8'h1B) m_kl[0] = m_brk;
      end else begin
        if (b == 8'h75) m_kr[1] = m_brk;
        if (b == 8'h72) m_kr[0] = m_brk;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_reset();
    m_kl = 2'b11; m_kr = 2'b11; m_code = 8'h00; m_ext = 0; m_brk = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int sv0, fe0, fa0;
    logic par;
    bit good;
    sv0 = sv_cnt; fe0 = fe_cnt; fa0 = fall_cnt;
    par  = ~(^b) ^ bad_par;
    good = !bad_par && !bad_stop;
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    wait_cyc(30);
    if (good) model_byte(b);
    else begin m_ext = 0; m_brk = 0; end
    chk({tag, ".falls"}, fall_cnt - fa0, 11);
    chk({tag, ".valid"}, sv_cnt - sv0, good ? 1 : 0);
    chk({tag, ".err"}, fe_cnt - fe0, good ? 0 : 1);
    chk({tag, ".code"}, scan_code, m_code);
    chk({tag, ".kl"}, keys_left, m_kl);
    chk({tag, ".kr"}, keys_right, m_kr);
    if (good) chk({tag, ".lat"}, sv_lat, 1);
  endtask

  initial begin
    int sv0, fe0, fa0;
    logic [7:0] pool [8];
    pool = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hE1, 8'h00};

    wait_cyc(5);
    chk("rst.code", scan_code, 8'h00);
    chk("rst.valid", scan_valid, 1'b0);
    chk("rst.err", frame_err, 1'b0);
    chk("rst.kl", keys_left, 2'b11);
    chk("rst.kr", keys_right, 2'b11);
    rst_n = 1'b1;
    wait_cyc(20);

    frame("w_make", 8'h1D, 0, 0);
    chk("w_make.kl_abs", keys_left, 2'b01);
    frame("w_brk0", 8'hF0, 0, 0);
    frame("w_brk1", 8'h1D, 0, 0);
    chk("w_brk.kl_abs", keys_left, 2'b11);

    frame("up_e0", 8'hE0, 0, 0);
    frame("up_make", 8'h75, 0, 0);
    chk("up_make.kr_abs", keys_right, 2'b01);
    frame("up_e0b", 8'hE0, 0, 0);
    frame("up_f0", 8'hF0, 0, 0);
    frame("up_brk", 8'h75, 0, 0);
    chk("up_brk.kr_abs", keys_right, 2'b11);
    frame("bare75", 8'h75, 0, 0);
    chk("bare75.kr_abs", keys_right, 2'b11);

    frame("bad_par", 8'h1D, 1, 0);
    frame("bad_stop", 8'h1D, 0, 1);

    // Partial frame: start plus four data bits of 8'h1B, then silence.
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_bits({2'b11, 1'b0, 8'h1B, 1'b0}, 5);
    wait_cyc(TMO - 120);
    chk("tmo.early", fe_cnt - fe0, 0);
    wait_cyc(300);
    chk("tmo.err", fe_cnt - fe0, 1);
    chk("tmo.valid", sv_cnt - sv0, 0);
    m_ext = 0; m_brk = 0;
    frame("after_tmo", 8'h1B, 0, 0);
    chk("after_tmo.kl_abs", keys_left, 2'b10);

    // Short low glitch with data low: must not look like a start bit.
    sv0 = sv_cnt; fe0 = fe_cnt; fa0 = fall_cnt;
    ps2_dat = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b1;
    wait_cyc(2);
    ps2_dat = 1'b1;
    wait_cyc(30);
    chk("glitch.falls", fall_cnt - fa0, 0);
    chk("glitch.valid", sv_cnt - sv0, 0);
    chk("glitch.err", fe_cnt - fe0, 0);

    frame("both_held", 8'h1D, 0, 0);
    chk("both_held.kl_abs", keys_left, 2'b00);

    send_bits({2'b11, 1'b0, 8'h72, 1'b0}, 6);
    rst_n = 1'b0;
    #1;
    chk("midrst.code", scan_code, 8'h00);
    chk("midrst.valid", scan_valid, 1'b0);
    chk("midrst.err", frame_err, 1'b0);
    chk("midrst.kl", keys_left, 2'b11);
    chk("midrst.kr", keys_right, 2'b11);
    model_reset();
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(20);
    frame("post_rst", 8'h1D, 0, 0);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      int sel, err;
      sel = $urandom_range(0, 8);
      b   = (sel == 8) ? 8'($urandom) : pool[sel];
      err = $urandom_range(0, 9);
      frame($sformatf("rnd%0d", i), b, err == 0, err == 1);
    end

    chk("valid_width", sv_double, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
